// File: rtl/dc_pkg.sv
// Shared types and helpers for the DC-offset remover: FSM state encoding,
// default geometry and the saturating subtract used on the rewrite pass.
package dc_pkg;

    localparam int N_LOG2_DEF = 10;
    localparam int DATA_W_DEF = 10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SUM_RD   = 3'd1,
        SUM_ACC  = 3'd2,
        MEAN     = 3'd3,
        SUB_RD   = 3'd4,
        SUB_CALC = 3'd5,
        SUB_NEXT = 3'd6,
        DONE     = 3'd7
    } state_t;

    // a and m are unsigned sample values; result is a - m clamped to the
    // two's-complement range of a w-bit word.
    function automatic int sat_sub(input int a, input int m, input int w = DATA_W_DEF);
        int diff;
        int hi;
        int lo;
        diff = a - m;
        hi   = (1 << (w - 1)) - 1;
        lo   = -(1 << (w - 1));
        if (diff > hi) begin
            return hi;
        end else if (diff < lo) begin
            return lo;
        end
        return diff;
    endfunction

endpackage

// File: rtl/dc_remover.sv
// In-place DC removal over the shared sample RAM: a summing pass, then a
// subtract/saturate rewrite pass. Define DC_PEAK_OUT_EN to add peak_abs.
module dc_remover
    import dc_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              do_remove_dc,
    output logic              did_remove_dc,
    output logic              busy,
    output logic              rd_en,
    output logic [N_LOG2-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
`ifdef DC_PEAK_OUT_EN
    output logic [DATA_W-1:0] peak_abs,
`endif
    output logic [DATA_W-1:0] dc_mean
);

    localparam int ACC_W = DATA_W + N_LOG2;

    state_t                   state;
    logic [ACC_W-1:0]         acc;
    logic [N_LOG2-1:0]        idx;
    logic                     last_idx;
    logic signed [DATA_W-1:0] diff_sat;

    assign last_idx = (idx == {N_LOG2{1'b1}});
    assign diff_sat = DATA_W'(sat_sub(int'(32'(rd_data)), int'(32'(dc_mean)), DATA_W));

    // Outputs are registered so rd_en is high exactly during *_RD, wr_en
    // during SUB_NEXT and did_remove_dc during DONE; reads and writes never overlap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            did_remove_dc <= 1'b0;
            busy          <= 1'b0;
            rd_en         <= 1'b0;
            rd_addr       <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            dc_mean       <= '0;
            acc           <= '0;
            idx           <= '0;
        end else begin
            did_remove_dc <= 1'b0;
            rd_en         <= 1'b0;
            wr_en         <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_remove_dc) begin
                        acc     <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        state   <= SUM_RD;
                    end
                end
                SUM_RD: state <= SUM_ACC;
                SUM_ACC: begin
                    acc <= acc + ACC_W'(rd_data);
                    if (last_idx) begin
                        state <= MEAN;
                    end else begin
                        idx     <= idx + 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= idx + 1'b1;
                        state   <= SUM_RD;
                    end
                end
                // Truncating divide by N: the mean is the top DATA_W bits of the sum.
                MEAN: begin
                    dc_mean <= acc[ACC_W-1:N_LOG2];
                    idx     <= '0;
                    rd_en   <= 1'b1;
                    rd_addr <= '0;
                    state   <= SUB_RD;
                end
                SUB_RD: state <= SUB_CALC;
                SUB_CALC: begin
                    wr_en   <= 1'b1;
                    wr_addr <= idx;
                    wr_data <= diff_sat;
                    state   <= SUB_NEXT;
                end
                SUB_NEXT: begin
                    if (last_idx) begin
                        did_remove_dc <= 1'b1;
                        state         <= DONE;
                    end else begin
                        idx     <= idx + 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= idx + 1'b1;
                        state   <= SUB_RD;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DC_PEAK_OUT_EN
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic        [DATA_W-1:0] ABS_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] abs_sat;

    // |-2^(DATA_W-1)| does not fit, so it is clamped to the positive limit.
    always_comb begin
        abs_sat = unsigned'(diff_sat);
        if (diff_sat == SAT_MIN) begin
            abs_sat = ABS_MAX;
        end else if (diff_sat[DATA_W-1]) begin
            abs_sat = unsigned'(-diff_sat);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_abs <= '0;
        end else if (state == IDLE && do_remove_dc) begin
            peak_abs <= '0;
        end else if (state == SUB_CALC && abs_sat > peak_abs) begin
            peak_abs <= abs_sat;
        end
    end
`else
    // Peak tracking not built; core datapath above is unchanged.
`endif

endmodule

// File: tb/tb_dc_remover.sv
// Randomised scoreboard bench for dc_remover; expected RAM writes come from
// a mean/subtract/clamp reference computed when each run is accepted.
module tb_dc_remover;

    localparam int N_LOG2 = 10;
    localparam int DATA_W = 10;
    localparam int N      = 1 << N_LOG2;
    localparam int LAT    = 2*N + 1 + 3*N + 1;
    localparam int VMAX   = (1 << (DATA_W-1)) - 1;
    localparam int VMIN   = -(1 << (DATA_W-1));

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              do_remove_dc = 1'b0;
    logic              did_remove_dc;
    logic              busy;
    logic              rd_en;
    logic [N_LOG2-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [N_LOG2-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] dc_mean;
`ifdef DC_PEAK_OUT_EN
    logic [DATA_W-1:0] peak_abs;
`endif

    always #5 clk = ~clk;

    dc_remover dut (
        .clk(clk), .rst(rst), .do_remove_dc(do_remove_dc), .did_remove_dc(did_remove_dc),
        .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef DC_PEAK_OUT_EN
        .peak_abs(peak_abs),
`endif
        .dc_mean(dc_mean)
    );

    // Sample RAM: registered read, bulk load from init_mem while the DUT is idle.
    logic [DATA_W-1:0] mem      [N];
    logic [DATA_W-1:0] init_mem [N];
    logic              load = 1'b0;
    int                cyc  = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load) begin
            for (int i = 0; i < N; i++) mem[i] <= init_mem[i];
        end else begin
            if (rd_en) rd_data <= mem[rd_addr];
            if (wr_en) mem[wr_addr] <= wr_data;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_q[$];
    int  exp_mean, exp_peak;
    int  start_cyc, last_did_cyc;
    int  n_starts = 0, n_dids = 0, wr_cnt = 0, wr_total = 0;
    bit  b2b_expect = 1'b0;

    // Reference: mean is floor(sum/N); each output is sample - mean clamped
    // to the signed DATA_W range, written back to its own address in order.
    task automatic model_run();
        longint sum;
        int     mean, v, a, pk;
        wr_t    w;
        sum = 0;
        pk  = 0;
        for (int k = 0; k < N; k++) sum += mem[k];
        mean = int'(sum / N);
        for (int k = 0; k < N; k++) begin
            v = int'(mem[k]) - mean;
            if (v > VMAX) v = VMAX;
            if (v < VMIN) v = VMIN;
            w.addr = k;
            w.data = v;
            exp_q.push_back(w);
            a = (v < 0) ? -v : v;
            if (a > VMAX) a = VMAX;
            if (a > pk) pk = a;
        end
        exp_mean = mean;
        exp_peak = pk;
    endtask

    // Monitor / scoreboard
    initial begin
        bit  prev_busy;
        bit  prev_did;
        wr_t w;
        prev_busy = 1'b0;
        prev_did  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_busy = 1'b0;
                prev_did  = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    n_starts++;
                    start_cyc = cyc;
                    wr_cnt    = 0;
                    if (b2b_expect) begin
                        chk("b2b_start_cycle", cyc, last_did_cyc + 2);
                        b2b_expect = 1'b0;
                    end
                    model_run();
                end
                if (busy) chk("rd_wr_exclusive", rd_en & wr_en, 0);
                if (wr_en) begin
                    wr_cnt++;
                    wr_total++;
                    chk("wr_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        chk("wr_addr", wr_addr, w.addr);
                        chk("wr_data", int'($signed(wr_data)), w.data);
                    end
                end
                if (did_remove_dc) begin
                    n_dids++;
                    last_did_cyc = cyc;
                    chk("did_single_cycle", prev_did, 0);
                    chk("latency", cyc - start_cyc + 1, LAT);
                    chk("busy_at_done", busy, 1);
                    chk("dc_mean", dc_mean, exp_mean);
                    chk("wr_count", wr_cnt, N);
                    chk("writes_outstanding", exp_q.size(), 0);
`ifdef DC_PEAK_OUT_EN
                    chk("peak_abs", peak_abs, exp_peak);
`endif
                end
                prev_busy = busy;
                prev_did  = did_remove_dc;
            end
        end
    end

    task automatic load_mem();
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic wait_did(input string name);
        int base;
        base = n_dids;
        for (int i = 0; i < LAT + 50 && n_dids == base; i++) @(negedge clk);
        chk(name, n_dids - base, 1);
    endtask

    task automatic wait_start(input string name);
        int base;
        base = n_starts;
        for (int i = 0; i < 10 && n_starts == base; i++) @(negedge clk);
        chk(name, n_starts - base, 1);
    endtask

    task automatic run_once(input string name);
        @(negedge clk) do_remove_dc = 1'b1;
        @(negedge clk) do_remove_dc = 1'b0;
        wait_did(name);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_did"},     did_remove_dc, 0);
        chk({tag, "_busy"},    busy, 0);
        chk({tag, "_rd_en"},   rd_en, 0);
        chk({tag, "_wr_en"},   wr_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_dc_mean"}, dc_mean, 0);
`ifdef DC_PEAK_OUT_EN
        chk({tag, "_peak"},    peak_abs, 0);
`endif
    endtask

    task automatic fill_random(input int base, input int spread);
        int v;
        for (int k = 0; k < N; k++) begin
            v = base + int'($urandom_range(spread));
            if (v > 1023) v = 1023;
            init_mem[k] = DATA_W'(v);
        end
        load_mem();
    endtask

    initial begin
        int ds, dd, wt;

        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Constant input
        for (int k = 0; k < N; k++) init_mem[k] = 10'd300;
        load_mem();
        run_once("done_const");
        chk("const_mean", dc_mean, 300);
        chk("const_mem0", int'($signed(mem[0])), 0);
        chk("const_mem1023", int'($signed(mem[1023])), 0);

        // Ramp
        for (int k = 0; k < N; k++) init_mem[k] = DATA_W'(k);
        load_mem();
        run_once("done_ramp");
        chk("ramp_mean", dc_mean, 511);
        chk("ramp_mem0", int'($signed(mem[0])), -511);
        chk("ramp_mem1022", int'($signed(mem[1022])), 511);
        chk("ramp_mem1023", int'($signed(mem[1023])), 511);

        // Alternating 0 / 486
        for (int k = 0; k < N; k++) init_mem[k] = (k % 2 == 0) ? 10'd0 : 10'd486;
        load_mem();
        run_once("done_alt");
        chk("alt_mean", dc_mean, 243);
        chk("alt_mem0", int'($signed(mem[0])), -243);
        chk("alt_mem1", int'($signed(mem[1])), 243);
`ifdef DC_PEAK_OUT_EN
        chk("alt_peak", peak_abs, 243);
`endif

        // Full scale with one zero
        for (int k = 0; k < N; k++) init_mem[k] = 10'd1023;
        init_mem[5] = 10'd0;
        load_mem();
        run_once("done_fs");
        chk("fs_mean", dc_mean, 1022);
        chk("fs_mem5", int'($signed(mem[5])), -512);
        chk("fs_mem6", int'($signed(mem[6])), 1);
`ifdef DC_PEAK_OUT_EN
        chk("fs_peak", peak_abs, 511);
`endif

        // Random data
        fill_random(0, 1023);
        run_once("done_rand_full");
        fill_random(400, 200);
        run_once("done_rand_narrow");

        // Start pulses during SUM and SUB phases are ignored
        fill_random(100, 700);
        ds = n_starts;
        dd = n_dids;
        @(negedge clk) do_remove_dc = 1'b1;
        @(negedge clk) do_remove_dc = 1'b0;
        repeat (100) @(negedge clk);
        do_remove_dc = 1'b1;
        @(negedge clk) do_remove_dc = 1'b0;
        repeat (3000) @(negedge clk);
        do_remove_dc = 1'b1;
        @(negedge clk) do_remove_dc = 1'b0;
        wait_did("done_ignore");
        repeat (5) @(negedge clk);
        chk("ignore_starts", n_starts - ds, 1);
        chk("ignore_dids", n_dids - dd, 1);
        chk("ignore_idle", busy, 0);

        // Held request: second run begins the cycle after DONE
        fill_random(0, 1023);
        ds = n_starts;
        @(negedge clk) do_remove_dc = 1'b1;
        wait_start("b2b_first_start");
        b2b_expect = 1'b1;
        wait_did("done_b2b_first");
        wait_start("b2b_second_start");
        do_remove_dc = 1'b0;
        wait_did("done_b2b_second");
        repeat (5) @(negedge clk);
        chk("b2b_starts", n_starts - ds, 2);
        chk("b2b_idle", busy, 0);

        // Reset in the middle of the subtract pass at idx 100
        fill_random(0, 1023);
        @(negedge clk) do_remove_dc = 1'b1;
        @(negedge clk) do_remove_dc = 1'b0;
        for (int i = 0; i < LAT && !(rd_en && rd_addr == 10'd100 && wr_total > 0 && n_starts > n_dids
                                     && cyc - start_cyc > 2*N); i++)
            @(negedge clk);
        chk("midrst_reached", rd_en && rd_addr == 10'd100, 1);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        wt = wr_total;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_no_writes", wr_total - wt, 0);
        chk("midrst_idle", busy, 0);
        fill_random(200, 600);
        run_once("done_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
